pipe_reg_skid: RTL and testbench
================================

// Module: pipe_reg_skid
// PURPOSE
// - Parametrised pipeline register. Successor to the fixed 32-bit clocked register.
// - Adds a valid/ready handshake, a 2-entry skid buffer, synchronous flush and a configurable reset value.
// - Sits between datapath stages (e.g. IF/ID, ID/EX) so a downstream stall never drops or duplicates data.
// - in_ready is driven from a register, so there is no combinational path from out_ready to in_ready.
// PARAMETERS
// - WIDTH      32  data width in bits (>=1)
// - RESET_VAL  0   value of out_data and the skid register after reset/flush (WIDTH bits)
// - CNT_W      16  width of stall_cnt (used only with PIPE_REG_STATS_EN)
// PORTS
// - clk        in   1      rising-edge clock
// - reset      in   1      synchronous, active-high reset
// - flush      in   1      synchronous discard of all held entries
// - in_valid   in   1      upstream data valid
// - in_ready   out  1      block can accept; registered
// - in_data    in   WIDTH  upstream data
// - out_valid  out  1      out_data valid
// - out_ready  in   1      downstream accepts
// - out_data   out  WIDTH  held data; registered
// - stall_cnt  out  CNT_W  stall-cycle counter; present only with PIPE_REG_STATS_EN
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
// - Transfers: an input transfer is in_valid&in_ready; an output transfer is out_valid&out_ready,
//   both sampled at the posedge.
// - Storage: main register (out_data/out_valid) and skid register (skid_data/skid_valid).
// - State encoding: EMPTY = !out_valid; ONE = out_valid&!skid_valid; TWO = out_valid&skid_valid.
// - in_ready = !skid_valid, i.e. high in EMPTY and ONE, low in TWO.
// - EMPTY:
//   - in_valid: main<=in_data, go to ONE.
//   - otherwise: stay in EMPTY.
// - ONE:
//   - in_valid&out_ready: main<=in_data, stay in ONE (full throughput).
//   - in_valid&!out_ready: skid<=in_data, go to TWO.
//   - !in_valid&out_ready: go to EMPTY.
//   - otherwise: hold.
// - TWO:
//   - out_ready: main<=skid_data, go to ONE. in_data is ignored because in_ready=0.
//   - otherwise: hold.
// - Latency: 1 cycle from input transfer to out_valid when the block is EMPTY.
// - Throughput: 1 word/cycle while out_ready stays high.
// - Ordering: strict FIFO. No word is ever dropped or duplicated outside flush/reset.
// - Output stability: out_data must stay unchanged while out_valid&!out_ready.
// - Flush: at the next posedge, out_valid=0, skid_valid=0, out_data=RESET_VAL and state is EMPTY.
//   - An input offered in the same cycle as flush is discarded.
//   - in_ready=1 in the cycle after flush.
// - Priority: reset > flush > handshake.
// - Reset values (also the values after reset mid-operation):
//   - out_valid=0, in_ready=1, out_data=RESET_VAL, skid_data=RESET_VAL, stall_cnt=0.
// - When !out_valid, out_data holds its last value; consumers must ignore it.
// CONFIGURATION
// - PIPE_REG_STATS_EN defined:
//   - stall_cnt increments by 1 on every cycle with out_valid&!out_ready.
//   - It saturates at all-ones and never wraps.
//   - It is cleared only by reset; flush does not clear it.
// - PIPE_REG_STATS_EN undefined: the stall_cnt port and its counter logic are absent.
// - All other behaviour is identical in both builds.
// TESTING
// - Reset: reset=1 for 2 cycles, WIDTH=32, RESET_VAL=32'hDEADBEEF
//   -> out_valid=0, in_ready=1, out_data=32'hDEADBEEF.
// - Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles
//   -> out_data 1,2,3,4 with out_valid=1, each one cycle after input.
// - Backpressure: send A=5, B=6 with out_ready=0 -> state TWO, in_ready=0, out_data=5.
//   Then raise out_ready -> 5 then 6 delivered, in_ready=1 after 5 leaves.
// - Flush with input: state TWO, then flush=1 with in_valid=1 and data 9
//   -> next cycle out_valid=0, in_ready=1, out_data=RESET_VAL, and 9 never appears.
// - Reset mid-stream: state ONE holding 7, reset=1 with in_valid=1 -> out_valid=0 and 7 lost.
//   After reset release the next input passes normally.
// - Stats (PIPE_REG_STATS_EN, CNT_W=4): hold out_valid=1 with out_ready=0 for 20 cycles
//   -> stall_cnt=15 (saturated). Then flush -> still 15. Then reset -> 0.

Source files
------------

// File: rtl/pipe_reg_skid.sv
// Pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_REG_STATS_EN to add the saturating stall_cnt output.
module pipe_reg_skid #(
   parameter int unsigned      WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   // bit 0 is out_valid, bit 1 is skid_valid, so both handshake
   // outputs come straight from flops
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             ld_main_in;
   logic             ld_main_skid;
   logic             ld_skid_in;

   generate
      if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
         $error("pipe_reg_skid: WIDTH and CNT_W must be >= 1");
      end
   endgenerate

   // next-state and register load enables from the handshake
   always_comb begin
      state_d      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid_in   = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (in_valid) begin
               ld_main_in = 1'b1;
               state_d    = ONE;
            end
         end
         ONE: begin
            if (in_valid && out_ready) begin
               ld_main_in = 1'b1;
            end else if (in_valid) begin
               ld_skid_in = 1'b1;
               state_d    = TWO;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (out_ready) begin
               ld_main_skid = 1'b1;
               state_d      = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   // occupancy register; reset and flush both empty the block
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // data registers; main holds when nothing is loaded
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         main_q <= RESET_VAL;
         skid_q <= RESET_VAL;
      end else begin
         if (ld_main_in) begin
            main_q <= in_data;
         end else if (ld_main_skid) begin
            main_q <= skid_q;
         end
         if (ld_skid_in) begin
            skid_q <= in_data;
         end
      end
   end

   assign out_valid = state_q[0];
   assign in_ready  = ~state_q[1];
   assign out_data  = main_q;

`ifdef PIPE_REG_STATS_EN
   logic [CNT_W-1:0] cnt_q;

   // saturating stall counter; only reset clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (out_valid && !out_ready && cnt_q != '1) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Bench for pipe_reg_skid: directed vector table, random run
// against a queue model, and a stall counter sequence.
module tb_pipe_reg_skid;

   localparam logic [31:0] RV = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef PIPE_REG_STATS_EN
   logic [3:0]  stall_cnt;
`endif

   pipe_reg_skid #(
      .WIDTH(32),
      .RESET_VAL(RV),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
`ifdef PIPE_REG_STATS_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        r;
      logic        f;
      logic        iv;
      logic [31:0] d;
      logic        o;
      logic        eov;
      logic        eir;
      logic [31:0] eod;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(input logic r, f, iv,
                               input logic [31:0] d,
                               input logic o, eov, eir,
                               input logic [31:0] eod);
      vec_t v;
      v.r = r; v.f = f; v.iv = iv; v.d = d; v.o = o;
      v.eov = eov; v.eir = eir; v.eod = eod;
      return v;
   endfunction

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, f, iv,
                       input logic [31:0] d,
                       input logic o);
      reset     = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = o;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] q[$];
   logic [31:0] last_od;
   int          cnt_m;
   logic        r, f, iv, o, pop, push;
   logic [31:0] d;

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
      in_data = '0; out_ready = 1'b0;

      //            r  f  iv d   o   ov ir od
      tbl[0]  = mk(1, 0, 0, 0,  0,  0, 1, RV);
      tbl[1]  = mk(1, 0, 0, 0,  0,  0, 1, RV);
      tbl[2]  = mk(0, 0, 1, 1,  1,  1, 1, 1);
      tbl[3]  = mk(0, 0, 1, 2,  1,  1, 1, 2);
      tbl[4]  = mk(0, 0, 1, 3,  1,  1, 1, 3);
      tbl[5]  = mk(0, 0, 1, 4,  1,  1, 1, 4);
      tbl[6]  = mk(0, 0, 0, 0,  1,  0, 1, 4);
      tbl[7]  = mk(0, 0, 1, 5,  0,  1, 1, 5);
      tbl[8]  = mk(0, 0, 1, 6,  0,  1, 0, 5);
      tbl[9]  = mk(0, 0, 1, 7,  0,  1, 0, 5);
      tbl[10] = mk(0, 0, 0, 0,  1,  1, 1, 6);
      tbl[11] = mk(0, 0, 0, 0,  1,  0, 1, 6);
      tbl[12] = mk(0, 0, 1, 8,  0,  1, 1, 8);
      tbl[13] = mk(0, 0, 1, 10, 0,  1, 0, 8);
      tbl[14] = mk(0, 1, 1, 9,  0,  0, 1, RV);
      tbl[15] = mk(0, 0, 0, 0,  1,  0, 1, RV);
      tbl[16] = mk(0, 0, 1, 7,  0,  1, 1, 7);
      tbl[17] = mk(1, 0, 1, 11, 0,  0, 1, RV);
      tbl[18] = mk(0, 0, 1, 12, 1,  1, 1, 12);
      tbl[19] = mk(0, 0, 0, 0,  1,  0, 1, 12);

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].o);
         check($sformatf("tbl%0d out_valid", i),
               {31'd0, out_valid}, {31'd0, tbl[i].eov});
         check($sformatf("tbl%0d in_ready", i),
               {31'd0, in_ready}, {31'd0, tbl[i].eir});
         check($sformatf("tbl%0d out_data", i),
               out_data, tbl[i].eod);
      end

      cnt_m   = 0;
      last_od = RV;
      for (int i = 0; i < 600; i++) begin
         r  = (i == 0) || ($urandom_range(0, 99) == 0);
         f  = ($urandom_range(0, 15) == 0);
         iv = ($urandom_range(0, 2) != 0);
         o  = ($urandom_range(0, 2) != 0);
         d  = $urandom;
         if (q.size() > 0 && !o && cnt_m < 15) cnt_m++;
         if (r) cnt_m = 0;
         if (r || f) begin
            q.delete();
            last_od = RV;
         end else begin
            pop  = (q.size() > 0) && o;
            push = iv && (q.size() < 2);
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
            if (q.size() > 0) last_od = q[0];
         end
         step(r, f, iv, d, o);
         check($sformatf("rnd%0d out_valid", i),
               {31'd0, out_valid}, {31'd0, q.size() > 0});
         check($sformatf("rnd%0d in_ready", i),
               {31'd0, in_ready}, {31'd0, q.size() < 2});
         check($sformatf("rnd%0d out_data", i), out_data, last_od);
`ifdef PIPE_REG_STATS_EN
         check($sformatf("rnd%0d stall_cnt", i),
               {28'd0, stall_cnt}, cnt_m);
`endif
      end

`ifdef PIPE_REG_STATS_EN
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("stats reset", {28'd0, stall_cnt}, 0);
      step(0, 0, 1, 5, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
      check("stats saturate", {28'd0, stall_cnt}, 15);
      check("stats held data", out_data, 5);
      step(0, 1, 0, 0, 0);
      check("stats after flush", {28'd0, stall_cnt}, 15);
      check("stats flush valid", {31'd0, out_valid}, 0);
      step(1, 0, 0, 0, 0);
      check("stats after reset", {28'd0, stall_cnt}, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
